centroid_tracker: RTL

CENTROID_TRACKER -- requirements
Module: centroid_tracker

---
 rtl/centroid_tracker.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/centroid_tracker.sv
// centroid_tracker
// Accumulates the coordinates of colour-mask hits over a frame. At frame end it
// divides the coordinate sums by the hit count to produce a centroid measurement.
// Accumulation never stops, so the next frame is collected while the division runs.
module centroid_tracker #(
  parameter int DISP_WIDTH = 11,
  parameter int MIN_COUNT  = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DISP_WIDTH-1:0] pix_x,
  input  logic [DISP_WIDTH-1:0] pix_y,
  input  logic                  pix_valid,
  input  logic                  pix_hit,
  input  logic                  frame_end,
  output logic [DISP_WIDTH-1:0] z_x,
  output logic [DISP_WIDTH-1:0] z_y,
  output logic                  valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CNT_W  = 2 * DISP_WIDTH;
  localparam int SUM_W  = 3 * DISP_WIDTH;
  localparam int STEP_W = $clog2(SUM_W + 1);
  localparam int LANES  = 2;                 // lane 0 = x, lane 1 = y

  localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_COUNT);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, OUTPUT} state_t;

  state_t state_q, state_d;

  logic [SUM_W-1:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  div_q, div_d;           // snapshot of the hit count (divisor)
  logic [STEP_W-1:0] step_q, step_d;
  logic [DISP_WIDTH-1:0] z_x_q, z_x_d, z_y_q, z_y_d;
  logic valid_q, valid_d, overrun_q, overrun_d;

  logic                  hit;
  logic [SUM_W-1:0]      fsum_x, fsum_y;
  logic [CNT_W-1:0]      fcnt;
  logic                  enough;
  logic                  load, step_en, last_step;
  logic [LANES-1:0][SUM_W-1:0]      sum_in;
  logic [LANES-1:0][DISP_WIDTH-1:0] quot;

  // Final frame totals, including a hit that arrives together with frame_end
  always_comb begin
    hit    = pix_valid & pix_hit;
    fsum_x = sum_x_q + (hit ? SUM_W'(pix_x) : '0);
    fsum_y = sum_y_q + (hit ? SUM_W'(pix_y) : '0);
    fcnt   = cnt_q + CNT_W'(hit);
    enough = (fcnt >= MIN_CNT);
  end

  // Accumulators run in every state; any frame_end closes the frame and clears them
  always_comb begin
    sum_x_d = frame_end ? '0 : fsum_x;
    sum_y_d = frame_end ? '0 : fsum_y;
    cnt_d   = frame_end ? '0 : fcnt;
  end

  // FSM state register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: DIVIDE lasts SUM_W cycles, and OUTPUT lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_end && enough) state_d = DIVIDE;
      DIVIDE:  if (last_step)           state_d = OUTPUT;
      OUTPUT:                           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // FSM outputs and divider controls
  always_comb begin
    load      = (state_q == IDLE) && frame_end && enough;
    step_en   = (state_q == DIVIDE);
    last_step = step_en && (step_q == LAST_STEP);
    busy      = (state_q != IDLE);
  end

  // Divisor snapshot, step counter, result and pulse outputs
  always_comb begin
    div_d     = load ? fcnt : div_q;
    step_d    = load ? '0 : (step_en ? step_q + 1'b1 : step_q);
    valid_d   = (state_q == OUTPUT);
    z_x_d     = (state_q == OUTPUT) ? quot[0] : z_x_q;
    z_y_d     = (state_q == OUTPUT) ? quot[1] : z_y_q;
    overrun_d = frame_end && busy;
  end

  // Control and datapath registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sum_x_q   <= '0;
      sum_y_q   <= '0;
      cnt_q     <= '0;
      div_q     <= '0;
      step_q    <= '0;
      z_x_q     <= '0;
      z_y_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sum_x_q   <= sum_x_d;
      sum_y_q   <= sum_y_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      step_q    <= step_d;
      z_x_q     <= z_x_d;
      z_y_q     <= z_y_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sum_in[0] = fsum_x;
  assign sum_in[1] = fsum_y;

  // Two restoring dividers share the divisor. The quotient register starts out
  // holding the dividend and shifts in one quotient bit per cycle.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [SUM_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W:0]   shifted;

    // One restoring step: trial-subtract the divisor from the shifted remainder
    always_comb begin
      shifted = {rem_q, quo_q[SUM_W-1]};
      quo_d   = quo_q;
      rem_d   = rem_q;
      if (load) begin
        quo_d = sum_in[g];
        rem_d = '0;
      end else if (step_en) begin
        if (shifted >= {1'b0, div_q}) begin
          rem_d = CNT_W'(shifted - {1'b0, div_q});
          quo_d = {quo_q[SUM_W-2:0], 1'b1};
        end else begin
          rem_d = shifted[CNT_W-1:0];
          quo_d = {quo_q[SUM_W-2:0], 1'b0};
        end
      end
    end

    // Divider registers
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        quo_q <= '0;
        rem_q <= '0;
      end else begin
        quo_q <= quo_d;
        rem_q <= rem_d;
      end
    end

    // The mean never exceeds the coordinate range, so truncation is exact
    assign quot[g] = quo_q[DISP_WIDTH-1:0];
  end

  assign z_x     = z_x_q;
  assign z_y     = z_y_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule
